jtag_axi_master: RTL
====================

// Module: jtag_axi_master
// PURPOSE
// - Parametrised AXI4-Lite master for debug-module system-bus accesses (successor of the fire-and-forget JTAG memory port).
// - Accepts one request at a time from jtag_dm; drives AW/W or AR with full valid/ready tracking; waits for B or R.
// - Generates WSTRB from access size, lane-aligns data, checks alignment, applies optional address auto-increment and a bus timeout.
// - Returns one response per request: read data plus an error code.
// PARAMETERS
// ADDR_W     32   address width
// DATA_W     32   data width; legal values 32 or 64
// TMO_W      16   timeout counter width
// TMO_CYC    4095 wait cycles before abort; 0 disables the timeout
// PORTS
// clk            in   1        system clock
// rst_n          in   1        async active-low reset
// req_valid_i    in   1        request from DM
// req_ready_o    out  1        bridge idle, request accepted
// req_we_i       in   1        1 = write, 0 = read
// req_addr_i     in   ADDR_W   byte address
// req_size_i     in   3        log2 of bytes: 0 = B, 1 = H, 2 = W, 3 = D (DATA_W=64 only)
// req_wdata_i    in   DATA_W   right-aligned write data
// req_autoinc_i  in   1        add (1<<size) to next_addr_o after a successful access
// rsp_valid_o    out  1        response valid
// rsp_ready_i    in   1        DM consumes response
// rsp_rdata_o    out  DATA_W   right-aligned read data, zero-extended
// rsp_err_o      out  2        0 = OK, 1 = bus error, 2 = timeout, 3 = misaligned/bad size
// next_addr_o    out  ADDR_W   last address, or auto-incremented address
// busy_o         out  1        state != IDLE
// m_axi_aw*/w*/b*/ar*/r*       AXI4-Lite master channels; widths per ADDR_W/DATA_W
//                              awprot/arprot = 3'b000
// BEHAVIOUR
// - Reset values:
//   - All valids 0; bready, rready 0.
//   - rsp_rdata_o, rsp_err_o, next_addr_o 0; busy_o 0; req_ready_o 1.
// - FSM states: IDLE, WREQ, WRSP, RREQ, RRSP, RESP.
//   - IDLE: req_ready_o = 1. On req_valid_i, latch the request.
//     - Size illegal, or addr[size-1:0] != 0: go to RESP with err 3 and no bus access.
//     - Otherwise go to WREQ (write) or RREQ (read) on the next cycle.
//   - WREQ: awvalid and wvalid assert together.
//     - Each drops individually once its own ready is seen; track aw_done and w_done.
//     - When both are done, go to WRSP with bready = 1.
//   - WRSP: on bvalid, err = bresp[1] ? 1 : 0; go to RESP.
//   - RREQ: arvalid until arready, then go to RRSP with rready = 1.
//   - RRSP: on rvalid, capture data and err = rresp[1] ? 1 : 0; go to RESP.
//   - RESP: rsp_valid_o = 1, outputs held stable until rsp_ready_i, then IDLE.
//     - Minimum request-to-response latency: 3 cycles when all readies are high (e.g. read: accept, AR, R, RESP).
// - Lane steering:
//   - lane = addr[log2(DATA_W/8)-1:0].
//   - wdata = req_wdata_i << (8*lane); wstrb = ((1<<(1<<size))-1) << lane.
//   - rsp_rdata_o = (rdata >> 8*lane) masked to 8<<size bits.
// - AXI address: full byte address, not word-aligned.
// - next_addr_o:
//   - Updated on entering RESP with err 0: addr + (autoinc ? 1<<size : 0), wrapping modulo 2^ADDR_W.
//   - Left unchanged on error.
// - Timeout:
//   - Counter clears on leaving IDLE and counts every cycle in WREQ/WRSP/RREQ/RRSP.
//   - At TMO_CYC, all valids/readies drop, err = 2, go to RESP. This is hung-fabric recovery only.
//   - Late B/R beats afterwards are ignored because bready/rready = 0.
// - Simultaneous events:
//   - bvalid/rvalid in the same cycle as timeout expiry: the bus response wins.
//   - awready/wready in the same cycle: both complete.
// - Async reset mid-transaction aborts immediately to reset values. The fabric must be reset in the same domain.
// - req_valid_i is ignored outside IDLE; request inputs are sampled only at acceptance.
// TESTING
// 1. Write W 0x1000_0004 = 0xDEADBEEF, all readies 1
//    -> one AW/W beat, wstrb = 4'hF, rsp err 0, next_addr 0x1000_0004.
// 2. Byte write at 0x...0003, data 0xA5, autoinc
//    -> wdata = 0xA500_0000, wstrb = 4'h8, next_addr = 0x...0004.
// 3. awready delayed 5 cycles, wready immediate
//    -> wvalid drops after 1 cycle, awvalid held 5 cycles, a single B consumed.
// 4. Half read at 0x...0002, rdata = 0x1234_5678
//    -> rsp_rdata 0x0000_1234, err 0; rresp = 2'b10 -> err 1.
// 5. Half read at 0x...0001 -> err 3, no AR issued.
//    Readies stuck at 0 with TMO_CYC = 8 -> err 2 after 8 cycles, arvalid low.
// 6. rsp_ready_i held 0 for 10 cycles -> response stable and req_ready_o 0 throughout.
//    rst_n asserted in WRSP -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/jtag_axi_master.sv
// jtag_axi_master
//   AXI4-Lite master used by the debug module for system-bus accesses.
//   It takes one request at a time and returns exactly one response for it.
//   The master builds WSTRB from the access size and lane-aligns the write data.
//   Read data is shifted back down to bit 0 and zero-extended.
//   Misaligned accesses and bad sizes are refused without touching the bus.
//   A bus timeout recovers from a hung fabric.
//
// Ports
//   clk, rst_n                 system clock, async active-low reset
//   req_*_i / req_ready_o      request from the DM (accepted only when idle)
//   rsp_*_o / rsp_ready_i      response: read data and error code
//                              (0 ok, 1 bus err, 2 timeout, 3 bad size/align)
//   next_addr_o                last successful address, auto-incremented if asked
//   busy_o                     any state other than IDLE
//   m_axi_*                    AXI4-Lite master channels AW, W, B, AR, R
//
// state | meaning
// IDLE  | ready for a request
// WREQ  | AW and W offered; each drops on its own handshake
// WRSP  | waiting for B
// RREQ  | AR offered
// RRSP  | waiting for R
// RESP  | response held until the DM takes it
module jtag_axi_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 4095
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [2:0]          req_size_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic                req_autoinc_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic [1:0]          rsp_err_o,
    output logic [ADDR_W-1:0]   next_addr_o,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   m_axi_awaddr_o,
    output logic [2:0]          m_axi_awprot_o,
    output logic                m_axi_awvalid_o,
    input  logic                m_axi_awready_i,
    output logic [DATA_W-1:0]   m_axi_wdata_o,
    output logic [DATA_W/8-1:0] m_axi_wstrb_o,
    output logic                m_axi_wvalid_o,
    input  logic                m_axi_wready_i,
    input  logic [1:0]          m_axi_bresp_i,
    input  logic                m_axi_bvalid_i,
    output logic                m_axi_bready_o,
    output logic [ADDR_W-1:0]   m_axi_araddr_o,
    output logic [2:0]          m_axi_arprot_o,
    output logic                m_axi_arvalid_o,
    input  logic                m_axi_arready_i,
    input  logic [DATA_W-1:0]   m_axi_rdata_i,
    input  logic [1:0]          m_axi_rresp_i,
    input  logic                m_axi_rvalid_i,
    output logic                m_axi_rready_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam logic [2:0] MAX_SIZE = 3'(LANE_W);
    localparam logic TMO_EN = (TMO_CYC != 0);
    // Down-counter loaded with TMO_CYC-1 so the terminal count (0) lands on
    // the TMO_CYC-th cycle spent in a bus state.
    localparam logic [TMO_W-1:0] TMO_LOAD = (TMO_CYC > 0) ? TMO_W'(TMO_CYC - 1) : '0;

    typedef enum logic [2:0] {IDLE, WREQ, WRSP, RREQ, RRSP, RESP} state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic               autoinc_q, autoinc_d;
    logic [2:0]         size_q, size_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         err_q, err_d;
    logic [ADDR_W-1:0]  next_addr_q, next_addr_d;

    logic [ADDR_W-1:0]  align_mask;
    logic               req_bad;
    logic [LANE_W-1:0]  lane;
    logic [15:0]        strb_base;
    logic [DATA_W-1:0]  rd_shift, rd_mask;
    logic               aw_now, w_now, tmo_hit, bus_state;
    logic               unused_resp;

    assign unused_resp = ^{m_axi_bresp_i[0], m_axi_rresp_i[0]};

    assign align_mask = (ADDR_W'(1) << req_size_i) - ADDR_W'(1);
    assign req_bad    = (req_size_i > MAX_SIZE) || ((req_addr_i & align_mask) != '0);

    assign lane      = addr_q[LANE_W-1:0];
    assign strb_base = (16'd1 << (4'd1 << size_q)) - 16'd1;
    assign rd_shift  = m_axi_rdata_i >> {lane, 3'b000};
    // A shift by the full data width yields 0, so a full-width access gets an all-ones mask.
    assign rd_mask   = ~({DATA_W{1'b1}} << (8 << size_q));

    assign aw_now    = aw_done_q | m_axi_awready_i;
    assign w_now     = w_done_q | m_axi_wready_i;
    assign tmo_hit   = TMO_EN && (tmo_q == '0);
    assign bus_state = (state_q == WREQ) || (state_q == WRSP) ||
                       (state_q == RREQ) || (state_q == RRSP);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        autoinc_d   = autoinc_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        tmo_d       = tmo_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        next_addr_d = next_addr_q;

        if (bus_state && (tmo_q != '0)) begin
            tmo_d = tmo_q - TMO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d      = req_we_i;
                    autoinc_d = req_autoinc_i;
                    size_d    = req_size_i;
                    addr_d    = req_addr_i;
                    wdata_d   = req_wdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    tmo_d     = TMO_LOAD;
                    rdata_d   = '0;
                    if (req_bad) begin
                        state_d = RESP;
                        err_d   = 2'd3;
                    end else begin
                        state_d = req_we_i ? WREQ : RREQ;
                    end
                end
            end
            WREQ: begin
                aw_done_d = aw_now;
                w_done_d  = w_now;
                if (aw_now && w_now) begin
                    state_d = WRSP;
                end else if (tmo_hit) begin
                    state_d = RESP;
                    err_d   = 2'd2;
                end
            end
            WRSP: begin
                // A B beat in the expiry cycle still counts.
                if (m_axi_bvalid_i) begin
                    state_d = RESP;
                    err_d   = m_axi_bresp_i[1] ? 2'd1 : 2'd0;
                end else if (tmo_hit) begin
                    state_d = RESP;
                    err_d   = 2'd2;
                end
            end
            RREQ: begin
                if (m_axi_arready_i) begin
                    state_d = RRSP;
                end else if (tmo_hit) begin
                    state_d = RESP;
                    err_d   = 2'd2;
                end
            end
            RRSP: begin
                if (m_axi_rvalid_i) begin
                    state_d = RESP;
                    rdata_d = rd_shift & rd_mask;
                    err_d   = m_axi_rresp_i[1] ? 2'd1 : 2'd0;
                end else if (tmo_hit) begin
                    state_d = RESP;
                    err_d   = 2'd2;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != RESP) && (state_d == RESP) && (err_d == 2'd0)) begin
            next_addr_d = addr_q + (autoinc_q ? (ADDR_W'(1) << size_q) : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            autoinc_q   <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            tmo_q       <= '0;
            rdata_q     <= '0;
            err_q       <= '0;
            next_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            autoinc_q   <= autoinc_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            tmo_q       <= tmo_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            next_addr_q <= next_addr_d;
        end
    end

    assign req_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign rsp_valid_o     = (state_q == RESP);
    assign rsp_rdata_o     = rdata_q;
    assign rsp_err_o       = err_q;
    assign next_addr_o     = next_addr_q;

    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awprot_o  = 3'b000;
    assign m_axi_awvalid_o = (state_q == WREQ) && !aw_done_q;
    assign m_axi_wdata_o   = wdata_q << {lane, 3'b000};
    assign m_axi_wstrb_o   = STRB_W'(strb_base << lane);
    assign m_axi_wvalid_o  = (state_q == WREQ) && !w_done_q;
    assign m_axi_bready_o  = (state_q == WRSP);
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arprot_o  = 3'b000;
    assign m_axi_arvalid_o = (state_q == RREQ);
    assign m_axi_rready_o  = (state_q == RRSP);

endmodule
